id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage placed directly upstream of the ALU. It registers the decoded instruction from ID under a valid/ready handshake and inserts load-use bubbles. It also honours branch flushes. From the registered state and the MEM/WB results it produces the forwarded ALU operands and the `aluop`.

## Interface
- `DATA_W`, 32, datapath width
- `REG_AW`, 5, register-index width
- `clk  in  1` rising-edge clock
- `rst  in  1` synchronous, active-high reset
- `id_valid  in  1` ID holds an instruction
- `id_ready  out  1` stage accepts ID this cycle
- `id_aluop  in  3` ALU opcode (000 add … 111 nop)
- `id_rs_data, id_rt_data  in  DATA_W` register-file read data
- `id_imm  in  DATA_W` sign-extended immediate
- `id_alusrc  in  1` 1: data2 = imm
- `id_rs, id_rt, id_rd  in  REG_AW` source and destination indices
- `id_rt_used  in  1` instruction reads rt (R-type, store, beq)
- `id_regwrite, id_memread, id_memwrite, id_branch  in  1` control bits
- `flush  in  1` branch-taken kill
- `ex_ready  in  1` downstream accepts the EX content
- `mem_regwrite, wb_regwrite  in  1`; `mem_rd, wb_rd  in  REG_AW`; `mem_result, wb_result  in  DATA_W` forwarding sources
- `ex_valid  out  1` EX content valid
- `ex_aluop  out  3`; `ex_data1, ex_data2  out  DATA_W` ALU inputs
- `ex_store_data  out  DATA_W` forwarded rt, used for stores
- `ex_rd  out  REG_AW`; `ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1`
- `hazard_stall  out  1` load-use interlock is active

## Operation
- `advance = ex_ready | ~ex_valid`.
- `hazard` is true when all of these hold:
  - `id_valid`, `ex_valid`, `ex_memread`
  - `ex_rd != 0`
  - `ex_rd == id_rs`, or (`id_rt_used` and `ex_rd == id_rt`)
- `hazard_stall = hazard & ~flush`.
- `id_ready = flush | (advance & ~hazard)`.
- Clock edge, in priority order:
  - `rst`: all registers are cleared, `ex_aluop` is set to 111, and all outputs are 0.
  - `flush`: `ex_valid <= 0`. The instruction offered by ID is consumed and dropped.
  - `advance & hazard`: a bubble is loaded (`ex_valid <= 0`, all control bits 0, `aluop` 111).
  - `advance & id_valid`: all fields are loaded and `ex_valid <= 1`.
  - `advance & ~id_valid`: `ex_valid <= 0`.
  - Hold (`ex_valid & ~ex_ready`): the fields keep their values, except that the registered rs/rt data are refreshed with the forwarded values. This ensures a producer that retires during the hold is not lost.
- A bubble's control bits are always 0, so it never writes the register file or memory.
- Forwarding selects between the registered rs/rt value and the MEM/WB results:
  - MEM result if `mem_regwrite`, `mem_rd != 0` and `mem_rd == ex_rs`.
  - Otherwise the WB result under the same condition.
  - Otherwise the registered value.
  - rt uses the same rule.
- `ex_data1` is the forwarded rs.
- `ex_data2` is `imm` when `alusrc` is set, otherwise the forwarded rt.
- `ex_store_data` is always the forwarded rt.
- Widths: all datapaths are exactly `DATA_W`. No extension is done here; ID supplies `imm` already sign-extended.

## Timing
- Latency is 1 cycle from the ID handshake to `ex_valid`.
- Forwarding muxes are combinational from registered state and the `mem_*`/`wb_*` inputs.
- `id_ready` is combinational from `ex_ready`, `flush`, the registered EX state and the ID indices.
- Load-use costs exactly one bubble cycle. On the next cycle the load is in MEM and its result is forwarded.
- `flush` together with `hazard` behaves as a flush: `hazard_stall` stays low and no bubble is counted.
- `flush` together with `~ex_ready` drops the EX content regardless of `ex_ready`.
- Reset mid-hold discards the held instruction. The first cycle after reset has `id_ready = 1`.

## Configuration
- `ID_EX_FORWARD_EN` defined: forwarding is implemented as described above.
- Not defined:
  - Operands are the raw registered values; the `mem_*`/`wb_*` inputs are ignored except for interlocking.
  - `hazard` is extended to any source match against an EX, MEM or WB producer with regwrite and `rd != 0`. A match in EX only counts when `ex_valid` is set.
  - Stall and flush semantics are unchanged.

## Structure
- Shared package `mips_pkg` holds:
  - ALU opcode constants (`ALU_ADD` … `ALU_NOP = 3'b111`)
  - the forward-select enum (`FWD_REG`, `FWD_MEM`, `FWD_WB`)
  - `DATA_W` and `REG_AW` defaults
- One sub-module, `fwd_sel`, instantiated twice (rs, rt). Inputs: register index, registered value and the MEM/WB sources. Output: the forwarded value.

## Test plan
- Reset → on the first cycle after reset, `ex_valid = 0`, `ex_aluop = 111`, all control outputs 0 and `id_ready = 1`.
- `lw $2` then `add $3,$2,$4` back to back → `hazard_stall = 1` for one cycle and one bubble is inserted. The add then issues with `ex_data1 = mem_result` (0xDEADBEEF).
- `add $5,…` producing 0x10 in MEM while `sub $6,$5,$5` is in EX → `ex_data1 = ex_data2 = 0x10`. Same rd also in WB with 0x20 → MEM wins (0x10).
- Destination `$0` in MEM with `mem_result = 0x55` → not forwarded; operand stays at the registered value 0.
- `ex_ready = 0` for 3 cycles while the WB producer of rs retires → after release, `ex_data1` equals the retired WB value and `id_ready` is 0 during the hold.
- `flush` asserted in the same cycle as a load-use hazard → `ex_valid = 0` next cycle, ID is consumed (`id_ready = 1`), and `hazard_stall = 0`.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS pipeline definitions: ALU opcodes, forward-select codes, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_NOR = 3'b110;
    localparam logic [2:0] ALU_NOP = 3'b111;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_e;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic branch;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX bus: decoded instruction, EX outputs and MEM/WB forwarding sources.
// Latency: n/a (wiring only).
// Backpressure: id_valid/id_ready toward ID, ex_valid/ex_ready toward the ALU side.
interface id_ex_stage_if #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
);
    logic              id_valid;
    logic              id_ready;
    logic [2:0]        id_aluop;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic              id_alusrc;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_rt_used;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_memwrite;
    logic              id_branch;
    logic              flush;
    logic              ex_ready;
    logic              mem_regwrite;
    logic              wb_regwrite;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] wb_result;
    logic              ex_valid;
    logic [2:0]        ex_aluop;
    logic [DATA_W-1:0] ex_data1;
    logic [DATA_W-1:0] ex_data2;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              ex_memwrite;
    logic              ex_branch;
    logic              hazard_stall;

    modport master (
        output id_valid, id_aluop, id_rs_data, id_rt_data, id_imm, id_alusrc,
               id_rs, id_rt, id_rd, id_rt_used, id_regwrite, id_memread,
               id_memwrite, id_branch, flush, ex_ready, mem_regwrite, wb_regwrite,
               mem_rd, wb_rd, mem_result, wb_result,
        input  id_ready, ex_valid, ex_aluop, ex_data1, ex_data2, ex_store_data,
               ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_branch, hazard_stall
    );

    modport slave (
        input  id_valid, id_aluop, id_rs_data, id_rt_data, id_imm, id_alusrc,
               id_rs, id_rt, id_rd, id_rt_used, id_regwrite, id_memread,
               id_memwrite, id_branch, flush, ex_ready, mem_regwrite, wb_regwrite,
               mem_rd, wb_rd, mem_result, wb_result,
        output id_ready, ex_valid, ex_aluop, ex_data1, ex_data2, ex_store_data,
               ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_branch, hazard_stall
    );

endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// Operand forwarding mux: MEM result beats WB result beats the registered value.
// Latency: combinational.
// Backpressure: none.
module fwd_sel #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] fwd_val
);
    import mips_pkg::*;

    fwd_e sel;

    // $0 is hardwired to zero, so a write to it is never a forwarding source.
    always_comb begin
        sel = FWD_REG;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        fwd_val = reg_val;
        case (sel)
            FWD_MEM: fwd_val = mem_result;
            FWD_WB:  fwd_val = wb_result;
            default: fwd_val = reg_val;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with load-use bubbles, flush and operand forwarding (ID_EX_FORWARD_EN).
// Latency: 1 cycle from ID handshake to ex_valid; operand muxes are combinational.
// Backpressure: holds while ex_valid & ~ex_ready (operands refreshed); id_ready drops on hold or hazard.
module id_ex_stage #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    import mips_pkg::*;

    logic              ex_valid_q;
    logic [2:0]        aluop_q;
    ctrl_t             ctrl_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic              alusrc_q;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic              advance;
    logic              hazard;

    function automatic logic reads_reg(input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] rs,
                                       input logic [REG_AW-1:0] rt,
                                       input logic              rt_used);
        return (rd != '0) && ((rd == rs) || (rt_used && (rd == rt)));
    endfunction

    assign advance = bus.ex_ready | ~ex_valid_q;

`ifdef ID_EX_FORWARD_EN
    localparam logic FWD_ON = 1'b1;

    // Only a load in EX cannot be covered by forwarding next cycle.
    assign hazard = bus.id_valid & ex_valid_q & ctrl_q.memread
                  & reads_reg(rd_q, bus.id_rs, bus.id_rt, bus.id_rt_used);
`else
    localparam logic FWD_ON = 1'b0;

    // Without forwarding, any in-flight producer of a source must retire first.
    assign hazard = bus.id_valid & (
          (ex_valid_q & (ctrl_q.regwrite | ctrl_q.memread)
                      & reads_reg(rd_q, bus.id_rs, bus.id_rt, bus.id_rt_used))
        | (bus.mem_regwrite & reads_reg(bus.mem_rd, bus.id_rs, bus.id_rt, bus.id_rt_used))
        | (bus.wb_regwrite  & reads_reg(bus.wb_rd,  bus.id_rs, bus.id_rt, bus.id_rt_used)));
`endif

    fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src          (rs_q),
        .reg_val      (rs_data_q),
        .mem_regwrite (bus.mem_regwrite & FWD_ON),
        .mem_rd       (bus.mem_rd),
        .mem_result   (bus.mem_result),
        .wb_regwrite  (bus.wb_regwrite & FWD_ON),
        .wb_rd        (bus.wb_rd),
        .wb_result    (bus.wb_result),
        .fwd_val      (rs_fwd)
    );

    fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src          (rt_q),
        .reg_val      (rt_data_q),
        .mem_regwrite (bus.mem_regwrite & FWD_ON),
        .mem_rd       (bus.mem_rd),
        .mem_result   (bus.mem_result),
        .wb_regwrite  (bus.wb_regwrite & FWD_ON),
        .wb_rd        (bus.wb_rd),
        .wb_result    (bus.wb_result),
        .fwd_val      (rt_fwd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            aluop_q    <= ALU_NOP;
            ctrl_q     <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            alusrc_q   <= 1'b0;
        end else if (bus.flush) begin
            ex_valid_q <= 1'b0;
        end else if (advance && hazard) begin
            ex_valid_q <= 1'b0;
            ctrl_q     <= '0;
            aluop_q    <= ALU_NOP;
        end else if (advance && bus.id_valid) begin
            ex_valid_q <= 1'b1;
            aluop_q    <= bus.id_aluop;
            ctrl_q     <= {bus.id_regwrite, bus.id_memread, bus.id_memwrite, bus.id_branch};
            rs_q       <= bus.id_rs;
            rt_q       <= bus.id_rt;
            rd_q       <= bus.id_rd;
            rs_data_q  <= bus.id_rs_data;
            rt_data_q  <= bus.id_rt_data;
            imm_q      <= bus.id_imm;
            alusrc_q   <= bus.id_alusrc;
        end else if (advance) begin
            ex_valid_q <= 1'b0;
        end else begin
            // Capture producers that retire while we are stalled downstream.
            rs_data_q <= rs_fwd;
            rt_data_q <= rt_fwd;
        end
    end

    assign bus.id_ready      = bus.flush | (advance & ~hazard);
    assign bus.hazard_stall  = hazard & ~bus.flush;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_aluop      = aluop_q;
    assign bus.ex_data1      = rs_fwd;
    assign bus.ex_data2      = alusrc_q ? imm_q : rt_fwd;
    assign bus.ex_store_data = rt_fwd;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_regwrite   = ctrl_q.regwrite;
    assign bus.ex_memread    = ctrl_q.memread;
    assign bus.ex_memwrite   = ctrl_q.memwrite;
    assign bus.ex_branch     = ctrl_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX transactions queued at issue, checked by a monitor.
// Expectations follow whichever ID_EX_FORWARD_EN build is compiled.
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0]  aluop;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm;
        logic        alusrc, rt_used, regw, memr, memw, br;
    } ins_t;

    typedef struct packed {
        logic [2:0]  aluop;
        logic [31:0] d1, d2, sd;
        logic [4:0]  rd;
        logic        regw, memr, memw, br;
    } exp_t;

    exp_t expq[$];
    exp_t mon_act;
    exp_t mon_exp;
    int   tests = 0;
    int   fails = 0;

    function automatic ins_t mk(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                                input logic [31:0] imm, input logic alusrc, input logic rt_used,
                                input logic regw, input logic memr, input logic memw, input logic br);
        ins_t i;
        i.aluop = op; i.rs = rs; i.rt = rt; i.rd = rd;
        i.rs_data = rsd; i.rt_data = rtd; i.imm = imm;
        i.alusrc = alusrc; i.rt_used = rt_used;
        i.regw = regw; i.memr = memr; i.memw = memw; i.br = br;
        return i;
    endfunction

    function automatic exp_t ex_of(input ins_t i, input logic [31:0] d1, input logic [31:0] rtv);
        exp_t e;
        e.aluop = i.aluop; e.d1 = d1; e.d2 = i.alusrc ? i.imm : rtv; e.sd = rtv;
        e.rd = i.rd; e.regw = i.regw; e.memr = i.memr; e.memw = i.memw; e.br = i.br;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input ins_t i);
        bus.id_valid    = 1'b1;
        bus.id_aluop    = i.aluop;
        bus.id_rs       = i.rs;
        bus.id_rt       = i.rt;
        bus.id_rd       = i.rd;
        bus.id_rs_data  = i.rs_data;
        bus.id_rt_data  = i.rt_data;
        bus.id_imm      = i.imm;
        bus.id_alusrc   = i.alusrc;
        bus.id_rt_used  = i.rt_used;
        bus.id_regwrite = i.regw;
        bus.id_memread  = i.memr;
        bus.id_memwrite = i.memw;
        bus.id_branch   = i.br;
    endtask

    task automatic idle();
        bus.id_valid = 1'b0;
    endtask

    task automatic set_fwd(input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
                           input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
        bus.mem_regwrite = mrw; bus.mem_rd = mrd; bus.mem_result = mres;
        bus.wb_regwrite  = wrw; bus.wb_rd  = wrd; bus.wb_result  = wres;
    endtask

    // Every EX transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.ex_valid && bus.ex_ready) begin
            mon_act.aluop = bus.ex_aluop;
            mon_act.d1    = bus.ex_data1;
            mon_act.d2    = bus.ex_data2;
            mon_act.sd    = bus.ex_store_data;
            mon_act.rd    = bus.ex_rd;
            mon_act.regw  = bus.ex_regwrite;
            mon_act.memr  = bus.ex_memread;
            mon_act.memw  = bus.ex_memwrite;
            mon_act.br    = bus.ex_branch;
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL ex_out: unexpected transfer %h", mon_act);
            end else begin
                mon_exp = expq.pop_front();
                if (mon_act !== mon_exp) begin
                    fails++;
                    $display("FAIL ex_out: got %h expected %h", mon_act, mon_exp);
                end
            end
        end
    end

    ins_t lw2, add3, sub6, sw9, zr, h12, xor15, lw16, use17, f20, lw18, addi19;

    initial begin
        lw2    = mk(3'b000, 5'd1,  5'd0,  5'd2,  32'h100,      32'h0,  32'h4,        1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add3   = mk(3'b000, 5'd2,  5'd4,  5'd3,  32'h11111111, 32'h44, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        sub6   = mk(3'b001, 5'd5,  5'd5,  5'd6,  32'h0,        32'h0,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        sw9    = mk(3'b000, 5'd7,  5'd9,  5'd0,  32'h70,       32'h90, 32'hFFFFFFF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        zr     = mk(3'b000, 5'd0,  5'd11, 5'd10, 32'h0,        32'h11, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        h12    = mk(3'b000, 5'd13, 5'd14, 5'd12, 32'h1300,     32'h14, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        xor15  = mk(3'b100, 5'd1,  5'd1,  5'd15, 32'h1,        32'h1,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        lw16   = mk(3'b000, 5'd1,  5'd0,  5'd16, 32'h200,      32'h0,  32'h8,        1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        use17  = mk(3'b000, 5'd16, 5'd16, 5'd17, 32'h0,        32'h0,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        f20    = mk(3'b010, 5'd1,  5'd2,  5'd20, 32'h3,        32'h4,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        lw18   = mk(3'b000, 5'd1,  5'd0,  5'd18, 32'h300,      32'h0,  32'hC,        1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addi19 = mk(3'b000, 5'd1,  5'd18, 5'd19, 32'h5,        32'h7,  32'h9,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        idle();
        offer(lw2);
        idle();
        bus.flush = 1'b0;
        bus.ex_ready = 1'b1;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk1("rst_ex_valid", bus.ex_valid, 1'b0);
        chk("rst_aluop", 32'(bus.ex_aluop), 32'd7);
        chk("rst_ctrl", 32'({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_branch, bus.ex_rd}), 32'd0);
        chk("rst_data", bus.ex_data1 | bus.ex_data2 | bus.ex_store_data, 32'h0);
        chk1("rst_id_ready", bus.id_ready, 1'b1);
        tick();

        // Load-use: lw $2 then add $3,$2,$4
        offer(lw2);
        @(negedge clk);
        chk1("lw_id_ready", bus.id_ready, 1'b1);
        expq.push_back(ex_of(lw2, 32'h100, 32'h0));
        tick();
        offer(add3);
        @(negedge clk);
        chk1("lu_stall", bus.hazard_stall, 1'b1);
        chk1("lu_id_ready", bus.id_ready, 1'b0);
        tick();
        set_fwd(1'b1, 5'd2, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk1("bubble_valid", bus.ex_valid, 1'b0);
        chk("bubble_aluop", 32'(bus.ex_aluop), 32'd7);
        chk("bubble_ctrl", 32'({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_branch}), 32'd0);
`ifdef ID_EX_FORWARD_EN
        chk1("lu_release", bus.id_ready, 1'b1);
        chk1("lu_stall_clr", bus.hazard_stall, 1'b0);
        expq.push_back(ex_of(add3, 32'hDEADBEEF, 32'h44));
        tick();
        idle();
        @(negedge clk);
        tick();
`else
        chk1("mem_interlock", bus.hazard_stall, 1'b1);
        chk1("mem_interlock_rdy", bus.id_ready, 1'b0);
        tick();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'hDEADBEEF);
        @(negedge clk);
        chk1("wb_interlock", bus.hazard_stall, 1'b1);
        tick();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        add3.rs_data = 32'hDEADBEEF;
        offer(add3);
        @(negedge clk);
        chk1("lu_release", bus.id_ready, 1'b1);
        expq.push_back(ex_of(add3, 32'hDEADBEEF, 32'h44));
        tick();
        idle();
        @(negedge clk);
        tick();
`endif
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // MEM beats WB; WB-only on rt; $0 never forwarded
        offer(sub6);
        @(negedge clk);
        chk1("sub_id_ready", bus.id_ready, 1'b1);
`ifdef ID_EX_FORWARD_EN
        expq.push_back(ex_of(sub6, 32'h10, 32'h10));
`else
        expq.push_back(ex_of(sub6, 32'h0, 32'h0));
`endif
        tick();
        set_fwd(1'b1, 5'd5, 32'h10, 1'b1, 5'd5, 32'h20);
        offer(sw9);
        @(negedge clk);
        chk1("sw_id_ready", bus.id_ready, 1'b1);
`ifdef ID_EX_FORWARD_EN
        expq.push_back(ex_of(sw9, 32'h70, 32'h99));
`else
        expq.push_back(ex_of(sw9, 32'h70, 32'h90));
`endif
        tick();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
        offer(zr);
        @(negedge clk);
        chk1("zr_id_ready", bus.id_ready, 1'b1);
        expq.push_back(ex_of(zr, 32'h0, 32'h11));
        tick();
        set_fwd(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
        offer(h12);
        @(negedge clk);
        chk1("h12_id_ready", bus.id_ready, 1'b1);
`ifdef ID_EX_FORWARD_EN
        expq.push_back(ex_of(h12, 32'hABCD, 32'h14));
`else
        expq.push_back(ex_of(h12, 32'h1300, 32'h14));
`endif
        tick();

        // Three-cycle hold while the WB producer of rs retires
        bus.ex_ready = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hABCD);
        offer(xor15);
        @(negedge clk);
        chk1("hold1_id_ready", bus.id_ready, 1'b0);
        chk1("hold1_stall", bus.hazard_stall, 1'b0);
        tick();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk1("hold2_id_ready", bus.id_ready, 1'b0);
        tick();
        @(negedge clk);
        chk1("hold3_id_ready", bus.id_ready, 1'b0);
        tick();
        bus.ex_ready = 1'b1;
        @(negedge clk);
        chk1("release_id_ready", bus.id_ready, 1'b1);
        expq.push_back(ex_of(xor15, 32'h1, 32'h1));
        tick();

        // Flush together with a load-use hazard
        offer(lw16);
        @(negedge clk);
        chk1("lw16_id_ready", bus.id_ready, 1'b1);
        expq.push_back(ex_of(lw16, 32'h200, 32'h0));
        tick();
        offer(use17);
        bus.flush = 1'b1;
        @(negedge clk);
        chk1("flush_stall", bus.hazard_stall, 1'b0);
        chk1("flush_id_ready", bus.id_ready, 1'b1);
        tick();
        bus.flush = 1'b0;
        idle();
        @(negedge clk);
        chk1("flush_ex_valid", bus.ex_valid, 1'b0);
        tick();

        // Flush during a hold drops the held instruction
        offer(f20);
        @(negedge clk);
        chk1("f20_id_ready", bus.id_ready, 1'b1);
        tick();
        idle();
        bus.ex_ready = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        chk1("flush_hold_valid", bus.ex_valid, 1'b0);
        bus.ex_ready = 1'b1;
        tick();

        // Reset during a hold
        offer(f20);
        @(negedge clk);
        tick();
        idle();
        bus.ex_ready = 1'b0;
        @(negedge clk);
        chk1("pre_rst_hold", bus.ex_valid, 1'b1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk1("rst_hold_valid", bus.ex_valid, 1'b0);
        chk1("rst_hold_id_ready", bus.id_ready, 1'b1);
        tick();
        bus.ex_ready = 1'b1;

        // rt only counts when the instruction reads it
        offer(lw18);
        @(negedge clk);
        chk1("lw18_id_ready", bus.id_ready, 1'b1);
        expq.push_back(ex_of(lw18, 32'h300, 32'h0));
        tick();
        offer(addi19);
        @(negedge clk);
        chk1("rt_unused_stall", bus.hazard_stall, 1'b0);
        chk1("rt_unused_id_ready", bus.id_ready, 1'b1);
        expq.push_back(ex_of(addi19, 32'h5, 32'h7));
        tick();
        idle();
        repeat (4) tick();
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
